row_trace_sequencer: RTL and testbench
======================================

# row_trace_sequencer

Sequences the ray tracer against the display so each visible row has exactly one traced result {side, size, texu} held stable for the row renderer. It sits between the tracer (start/done handshake) and the row renderer. It double-buffers results: a back register captures the tracer output, and a front register drives rendering and swaps at line boundaries. Late traces are aborted, counted and replaced by the previous row's data, so the display never loses sync.

## Interface
- `V_VIEW`, default 480: number of visible rows traced per frame (row indices 0..V_VIEW-1).
- `clk` in 1: pixel clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse; begins a new frame sequence.
- `line_end` in 1: one-cycle pulse on the last clock of every scan line.
- `trace_start` out 1: one-cycle request to tracer.
- `trace_row` out 10: row index being traced; stable from `trace_start` until done/abort.
- `trace_abort` out 1: one-cycle pulse; cancels the in-flight trace.
- `trace_done` in 1: one-cycle pulse; result ports are valid this cycle.
- `trace_side` in 1, `trace_size` in 11, `trace_texu` in 6: tracer result.
- `row_side` out 1, `row_size` out 11, `row_texu` out 6: front register, feeds the row renderer.
- `row_valid` out 1: front register holds a row for the current line; when 0, the renderer output is ignored.
- `miss` out 1: one-cycle pulse when a line starts with no fresh result.
- `miss_count` out 8: saturating misses in the current frame.

## Operation
- State registers:
  - front {side, size, texu, valid}
  - back {side, size, texu, full}
  - `next_row` (10 bits)
  - FSM state: IDLE, ISSUE, WAIT, READY.
- Reset: state IDLE, all registers and outputs 0.
- `frame_start` (any state) has priority over all other events:
  - front.valid←0, back.full←0, next_row←0, miss_count←0.
  - State→ISSUE.
  - If the state was WAIT, pulse `trace_abort` the same edge.
- ISSUE: `trace_start`=1, `trace_row`=next_row; →WAIT next cycle unconditionally.
- WAIT, `trace_done` without `line_end`: back←result, full←1, →READY.
- WAIT, `trace_done` coincides with `line_end` (bypass, not a miss):
  - front←result, valid←1.
  - If next_row==V_VIEW-1 →IDLE, else next_row+1, →ISSUE.
- READY, `line_end`:
  - front←back, valid←1, full←0.
  - If next_row==V_VIEW-1 →IDLE, else next_row+1, →ISSUE.
- WAIT or ISSUE, `line_end` with no `trace_done` (miss):
  - Front unchanged (previous row repeats), `miss` pulse, miss_count+1 saturating at 255.
  - `trace_abort` pulse, even from ISSUE.
  - If next_row==V_VIEW-1 →IDLE, else next_row+1, →ISSUE.
- IDLE, `line_end`: front.valid←0 (clears the last row after its line).
- `trace_done` in IDLE, ISSUE or READY is a protocol violation; it is ignored, with no state change.
- Tracer contract:
  - Earliest `trace_done` is the cycle after `trace_start`.
  - After `trace_abort` the tracer is idle and emits no `trace_done` for that request.
- `frame_start` must precede the line_end that begins visible row 0 by at least one full line.

## Timing
- All outputs are registered; none is combinational from inputs.
- Front updates on the same clock edge that samples `line_end`=1; the new row is visible from the first clock of the next line.
- `trace_start` rises on the edge after the event that entered ISSUE (line_end, frame_start, or reset release + frame_start).
- `trace_abort` and `miss` assert for exactly one cycle, on the edge sampling `line_end` (or `frame_start`).
- `trace_row` changes only when entering ISSUE.
- Tracer budget per row: one line period minus 2 clocks.
- miss_count updates on the same edge as `miss`, holds through the frame, and clears only on `frame_start` or reset.
- Asserting `reset_n` low mid-trace returns to IDLE immediately. No abort is issued; the tracer is reset by the same signal.

## Test plan
- Reset: hold `reset_n`=0 with random inputs.
  - All outputs 0; state IDLE after release.
- Nominal, V_VIEW=4: `frame_start`, then the tracer answers each start after 10 cycles with size=row*100, texu=row; lines of 50 clocks.
  - trace_row sequence 0,1,2,3.
  - row_size 0,100,200,300 on consecutive lines, row_valid=1 for 4 lines, then 0 after the following line_end.
  - miss_count=0.
- Miss: V_VIEW=4, tracer withholds done for row 1.
  - At row 1's line_end: miss pulse, trace_abort pulse, row_size stays 0.
  - trace_row jumps to 2; miss_count=1.
- Bypass: `trace_done` coincident with `line_end` for row 2 (size=555).
  - row_size=555 on that edge; no miss.
- Saturation and restart: force 300 misses (V_VIEW=480, no tracer).
  - miss_count stops at 255.
  - `frame_start` mid-WAIT: trace_abort pulse, miss_count=0, row_valid=0, trace_start for row 0 next cycle.
- Violation: `trace_done` pulse while READY with size=999.
  - Back register unchanged; the READY data is displayed at the next line_end.

Source files
------------

// File: rtl/row_trace_sequencer.sv
// row_trace_sequencer: paces the ray tracer against the display scan so each
// visible row has exactly one traced result held stable for the row renderer.
// Results land in a back register and are swapped into the front register at
// line boundaries; late traces are aborted, counted, and the previous row repeats.
module row_trace_sequencer #(
  parameter int unsigned V_VIEW = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        line_end,
  output logic        trace_start,
  output logic [9:0]  trace_row,
  output logic        trace_abort,
  input  logic        trace_done,
  input  logic        trace_side,
  input  logic [10:0] trace_size,
  input  logic [5:0]  trace_texu,
  output logic        row_side,
  output logic [10:0] row_size,
  output logic [5:0]  row_texu,
  output logic        row_valid,
  output logic        miss,
  output logic [7:0]  miss_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_READY
  } state_t;

  localparam logic [9:0] LAST_ROW = 10'(V_VIEW - 1);

  state_t      r_state;
  state_t      w_state_nx;

  logic        r_front_side,  w_front_side_nx;
  logic [10:0] r_front_size,  w_front_size_nx;
  logic [5:0]  r_front_texu,  w_front_texu_nx;
  logic        r_front_valid, w_front_valid_nx;

  logic        r_back_side,   w_back_side_nx;
  logic [10:0] r_back_size,   w_back_size_nx;
  logic [5:0]  r_back_texu,   w_back_texu_nx;
  logic        r_back_full,   w_back_full_nx;

  logic [9:0]  r_next_row,    w_next_row_nx;
  logic [7:0]  r_miss_count,  w_miss_count_nx;
  logic        r_trace_start, w_trace_start_nx;
  logic        r_trace_abort, w_trace_abort_nx;
  logic        r_miss,        w_miss_nx;

  logic        w_last;

  assign w_last = (r_next_row == LAST_ROW);

  // Next-state and next-register computation; frame_start overrides every other event.
  always_comb begin
    w_state_nx       = r_state;
    w_front_side_nx  = r_front_side;
    w_front_size_nx  = r_front_size;
    w_front_texu_nx  = r_front_texu;
    w_front_valid_nx = r_front_valid;
    w_back_side_nx   = r_back_side;
    w_back_size_nx   = r_back_size;
    w_back_texu_nx   = r_back_texu;
    w_back_full_nx   = r_back_full;
    w_next_row_nx    = r_next_row;
    w_miss_count_nx  = r_miss_count;
    w_trace_abort_nx = 1'b0;
    w_miss_nx        = 1'b0;

    if (frame_start) begin
      w_front_valid_nx = 1'b0;
      w_back_full_nx   = 1'b0;
      w_next_row_nx    = '0;
      w_miss_count_nx  = '0;
      w_state_nx       = S_ISSUE;
      w_trace_abort_nx = (r_state == S_WAIT);
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (line_end) w_front_valid_nx = 1'b0;
        end
        S_ISSUE, S_WAIT: begin
          if (r_state == S_WAIT && trace_done && line_end) begin
            // Result arrived on the boundary edge: skip the back register.
            w_front_side_nx  = trace_side;
            w_front_size_nx  = trace_size;
            w_front_texu_nx  = trace_texu;
            w_front_valid_nx = 1'b1;
          end else if (r_state == S_WAIT && trace_done) begin
            w_back_side_nx = trace_side;
            w_back_size_nx = trace_size;
            w_back_texu_nx = trace_texu;
            w_back_full_nx = 1'b1;
            w_state_nx     = S_READY;
          end else if (line_end) begin
            // Trace too late: front keeps the previous row, tracer is cancelled.
            w_miss_nx        = 1'b1;
            w_trace_abort_nx = 1'b1;
            if (r_miss_count != 8'hFF) w_miss_count_nx = r_miss_count + 8'd1;
          end else if (r_state == S_ISSUE) begin
            w_state_nx = S_WAIT;
          end
          if (line_end) begin
            if (w_last) begin
              w_state_nx = S_IDLE;
            end else begin
              w_next_row_nx = r_next_row + 10'd1;
              w_state_nx    = S_ISSUE;
            end
          end
        end
        S_READY: begin
          if (line_end) begin
            w_front_side_nx  = r_back_side;
            w_front_size_nx  = r_back_size;
            w_front_texu_nx  = r_back_texu;
            w_front_valid_nx = 1'b1;
            w_back_full_nx   = 1'b0;
            if (w_last) begin
              w_state_nx = S_IDLE;
            end else begin
              w_next_row_nx = r_next_row + 10'd1;
              w_state_nx    = S_ISSUE;
            end
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end

    w_trace_start_nx = (w_state_nx == S_ISSUE);
  end

  // State and datapath registers; every output is taken straight from here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_front_side  <= 1'b0;
      r_front_size  <= '0;
      r_front_texu  <= '0;
      r_front_valid <= 1'b0;
      r_back_side   <= 1'b0;
      r_back_size   <= '0;
      r_back_texu   <= '0;
      r_back_full   <= 1'b0;
      r_next_row    <= '0;
      r_miss_count  <= '0;
      r_trace_start <= 1'b0;
      r_trace_abort <= 1'b0;
      r_miss        <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_front_side  <= w_front_side_nx;
      r_front_size  <= w_front_size_nx;
      r_front_texu  <= w_front_texu_nx;
      r_front_valid <= w_front_valid_nx;
      r_back_side   <= w_back_side_nx;
      r_back_size   <= w_back_size_nx;
      r_back_texu   <= w_back_texu_nx;
      r_back_full   <= w_back_full_nx;
      r_next_row    <= w_next_row_nx;
      r_miss_count  <= w_miss_count_nx;
      r_trace_start <= w_trace_start_nx;
      r_trace_abort <= w_trace_abort_nx;
      r_miss        <= w_miss_nx;
    end
  end

  // next_row only moves on transitions into ISSUE, so it doubles as trace_row.
  assign trace_start = r_trace_start;
  assign trace_row   = r_next_row;
  assign trace_abort = r_trace_abort;
  assign row_side    = r_front_side;
  assign row_size    = r_front_size;
  assign row_texu    = r_front_texu;
  assign row_valid   = r_front_valid;
  assign miss        = r_miss;
  assign miss_count  = r_miss_count;

endmodule

// File: tb/tb_row_trace_sequencer.sv
// Directed bench for row_trace_sequencer: a 4-row instance with a small tracer
// model covers nominal, miss, bypass, protocol violation and restart; a 480-row
// instance with a silent tracer covers miss counter saturation.
module tb_row_trace_sequencer;

  logic clk = 1'b0;
  logic reset_n;

  logic        a_frame_start, a_line_end, a_trace_start, a_trace_abort;
  logic        a_trace_done, a_trace_side, a_row_side, a_row_valid, a_miss;
  logic [9:0]  a_trace_row;
  logic [10:0] a_trace_size, a_row_size;
  logic [5:0]  a_trace_texu, a_row_texu;
  logic [7:0]  a_miss_count;

  logic        b_frame_start, b_line_end, b_trace_start, b_trace_abort;
  logic        b_trace_done, b_trace_side, b_row_side, b_row_valid, b_miss;
  logic [9:0]  b_trace_row;
  logic [10:0] b_trace_size, b_row_size;
  logic [5:0]  b_trace_texu, b_row_texu;
  logic [7:0]  b_miss_count;

  int n_checks = 0;
  int n_errors = 0;

  // Tracer model configuration for instance A, indexed by row.
  int          lat[4];
  logic [10:0] sz[4];
  bit          spur[4];
  logic [9:0]  rows[$];

  int m_cnt  = 0;
  int m_scnt = 0;
  int m_row  = 0;
  bit m_pend = 1'b0;

  row_trace_sequencer #(.V_VIEW(4)) u_dut_a (
    .clk(clk), .reset_n(reset_n),
    .frame_start(a_frame_start), .line_end(a_line_end),
    .trace_start(a_trace_start), .trace_row(a_trace_row), .trace_abort(a_trace_abort),
    .trace_done(a_trace_done), .trace_side(a_trace_side),
    .trace_size(a_trace_size), .trace_texu(a_trace_texu),
    .row_side(a_row_side), .row_size(a_row_size), .row_texu(a_row_texu),
    .row_valid(a_row_valid), .miss(a_miss), .miss_count(a_miss_count)
  );

  row_trace_sequencer #(.V_VIEW(480)) u_dut_b (
    .clk(clk), .reset_n(reset_n),
    .frame_start(b_frame_start), .line_end(b_line_end),
    .trace_start(b_trace_start), .trace_row(b_trace_row), .trace_abort(b_trace_abort),
    .trace_done(b_trace_done), .trace_side(b_trace_side),
    .trace_size(b_trace_size), .trace_texu(b_trace_texu),
    .row_side(b_row_side), .row_size(b_row_size), .row_texu(b_row_texu),
    .row_valid(b_row_valid), .miss(b_miss), .miss_count(b_miss_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic a_line(input int len);
    repeat (len - 1) tick();
    a_line_end = 1'b1;
    tick();
    a_line_end = 1'b0;
  endtask

  task automatic b_line(input int len);
    repeat (len - 1) tick();
    b_line_end = 1'b1;
    tick();
    b_line_end = 1'b0;
  endtask

  // Tracer model for A: answers each start after lat[row] cycles (0 = never),
  // drops the request on abort, optionally emits a stray done 4 cycles later.
  initial begin
    a_trace_done = 1'b0;
    a_trace_side = 1'b0;
    a_trace_size = '0;
    a_trace_texu = '0;
    forever begin
      tick();
      if (!reset_n) begin
        a_trace_done = 1'($urandom);
        a_trace_side = 1'($urandom);
        a_trace_size = 11'($urandom);
        a_trace_texu = 6'($urandom);
        m_pend = 1'b0;
        m_scnt = 0;
      end else begin
        a_trace_done = 1'b0;
        a_trace_side = 1'b0;
        a_trace_size = '0;
        a_trace_texu = '0;
        if (a_trace_abort) m_pend = 1'b0;
        if (m_pend) begin
          m_cnt--;
          if (m_cnt == 0) begin
            a_trace_done = 1'b1;
            a_trace_side = m_row[0];
            a_trace_size = sz[m_row];
            a_trace_texu = 6'(m_row);
            m_pend = 1'b0;
            if (spur[m_row]) m_scnt = 4;
          end
        end else if (m_scnt > 0) begin
          m_scnt--;
          if (m_scnt == 0) begin
            a_trace_done = 1'b1;
            a_trace_size = 11'd999;
            a_trace_texu = 6'd63;
            a_trace_side = 1'b1;
          end
        end
        if (a_trace_start) begin
          m_row = int'(a_trace_row) % 4;
          rows.push_back(a_trace_row);
          if (lat[m_row] != 0) begin
            m_pend = 1'b1;
            m_cnt  = lat[m_row];
          end
        end
      end
    end
  end

  initial begin
    b_trace_done = 1'b0;
    b_trace_side = 1'b0;
    b_trace_size = '0;
    b_trace_texu = '0;
    for (int i = 0; i < 4; i++) begin
      lat[i] = 10; sz[i] = 11'(i * 100); spur[i] = 1'b0;
    end

    // Reset with random inputs
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_frame_start = 1'($urandom); a_line_end = 1'($urandom);
      b_frame_start = 1'($urandom); b_line_end = 1'($urandom);
      tick();
    end
    chk("rst_a_outs", 32'({a_trace_start, a_trace_row, a_trace_abort, a_row_side, a_row_size,
                           a_row_texu, a_row_valid, a_miss, a_miss_count}), 0);
    chk("rst_b_outs", 32'({b_trace_start, b_trace_row, b_trace_abort, b_row_side, b_row_size,
                           b_row_texu, b_row_valid, b_miss, b_miss_count}), 0);
    a_frame_start = 1'b0; a_line_end = 1'b0;
    b_frame_start = 1'b0; b_line_end = 1'b0;
    reset_n = 1'b1;
    repeat (3) tick();
    chk("idle_a_start", 32'(a_trace_start), 0);
    chk("idle_a_valid", 32'(a_row_valid), 0);

    // Frame 1: nominal
    rows.delete();
    a_frame_start = 1'b1; tick(); a_frame_start = 1'b0;
    chk("f1_start", 32'(a_trace_start), 1);
    chk("f1_row0", 32'(a_trace_row), 0);
    for (int r = 0; r < 4; r++) begin
      a_line(50);
      chk("f1_size", 32'(a_row_size), 32'(r * 100));
      chk("f1_texu", 32'(a_row_texu), 32'(r));
      chk("f1_side", 32'(a_row_side), 32'(r % 2));
      chk("f1_valid", 32'(a_row_valid), 1);
      chk("f1_miss", 32'(a_miss), 0);
      chk("f1_abort", 32'(a_trace_abort), 0);
    end
    a_line(50);
    chk("f1_valid_end", 32'(a_row_valid), 0);
    chk("f1_start_end", 32'(a_trace_start), 0);
    chk("f1_misscnt", 32'(a_miss_count), 0);
    chk("f1_nrows", 32'(rows.size()), 4);
    for (int i = 0; i < 4 && i < rows.size(); i++) chk("f1_trace_row", 32'(rows[i]), 32'(i));

    // Frame 2: row 1 missed, row 2 bypass, stray done while READY on row 3
    lat[0] = 10; lat[1] = 0; lat[2] = 49; lat[3] = 10;
    sz[0] = 11'd0; sz[1] = 11'd100; sz[2] = 11'd555; sz[3] = 11'd300;
    spur[3] = 1'b1;
    rows.delete();
    a_frame_start = 1'b1; tick(); a_frame_start = 1'b0;
    a_line(50);
    chk("f2_r0_size", 32'(a_row_size), 0);
    chk("f2_r0_valid", 32'(a_row_valid), 1);
    a_line(50);
    chk("f2_miss", 32'(a_miss), 1);
    chk("f2_abort", 32'(a_trace_abort), 1);
    chk("f2_hold_size", 32'(a_row_size), 0);
    chk("f2_hold_valid", 32'(a_row_valid), 1);
    chk("f2_jump_row", 32'(a_trace_row), 2);
    chk("f2_jump_start", 32'(a_trace_start), 1);
    chk("f2_misscnt1", 32'(a_miss_count), 1);
    tick();
    chk("f2_miss_pulse", 32'(a_miss), 0);
    chk("f2_abort_pulse", 32'(a_trace_abort), 0);
    a_line(49);
    chk("f2_bypass_size", 32'(a_row_size), 555);
    chk("f2_bypass_texu", 32'(a_row_texu), 2);
    chk("f2_bypass_miss", 32'(a_miss), 0);
    chk("f2_bypass_abort", 32'(a_trace_abort), 0);
    chk("f2_bypass_cnt", 32'(a_miss_count), 1);
    a_line(50);
    chk("f2_viol_size", 32'(a_row_size), 300);
    chk("f2_viol_texu", 32'(a_row_texu), 3);
    a_line(50);
    chk("f2_valid_end", 32'(a_row_valid), 0);
    chk("f2_cnt_hold", 32'(a_miss_count), 1);

    // Frame 3: restart while WAIT on row 1 after row 0 is displayed
    lat[1] = 10; spur[3] = 1'b0;
    a_frame_start = 1'b1; tick(); a_frame_start = 1'b0;
    chk("f3_cnt_clr", 32'(a_miss_count), 0);
    a_line(50);
    chk("f3_r0_valid", 32'(a_row_valid), 1);
    tick(); tick();
    chk("f3_wait_nostart", 32'(a_trace_start), 0);
    a_frame_start = 1'b1; tick(); a_frame_start = 1'b0;
    chk("f3_rs_abort", 32'(a_trace_abort), 1);
    chk("f3_rs_valid", 32'(a_row_valid), 0);
    chk("f3_rs_start", 32'(a_trace_start), 1);
    chk("f3_rs_row", 32'(a_trace_row), 0);
    tick();
    chk("f3_rs_abort_pulse", 32'(a_trace_abort), 0);
    chk("f3_rs_start_pulse", 32'(a_trace_start), 0);

    // Saturation on B: 300 consecutive misses
    b_frame_start = 1'b1; tick(); b_frame_start = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      b_line(4);
      if (k == 1) begin
        chk("sat_miss1", 32'(b_miss), 1);
        chk("sat_abort1", 32'(b_trace_abort), 1);
        chk("sat_cnt1", 32'(b_miss_count), 1);
      end
      if (k == 254) chk("sat_cnt254", 32'(b_miss_count), 254);
      if (k == 255) chk("sat_cnt255", 32'(b_miss_count), 255);
      if (k == 256) chk("sat_cnt256", 32'(b_miss_count), 255);
      if (k == 300) begin
        chk("sat_cnt300", 32'(b_miss_count), 255);
        chk("sat_row300", 32'(b_trace_row), 300);
      end
    end
    tick();
    b_frame_start = 1'b1; tick(); b_frame_start = 1'b0;
    chk("sat_rs_abort", 32'(b_trace_abort), 1);
    chk("sat_rs_cnt", 32'(b_miss_count), 0);
    chk("sat_rs_valid", 32'(b_row_valid), 0);
    chk("sat_rs_start", 32'(b_trace_start), 1);
    chk("sat_rs_row", 32'(b_trace_row), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
